regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Final pipeline stage of the processor. It takes the load result from the data-memory stage and the ALU result from the execute stage, registers one committing result per cycle, and commits it into the 32-entry general register file. It also drives the register-file read ports and the full register array used by execute and data-memory. An optional bypass forwards the pending result to the read ports one cycle early.

## Interface
Parameters:
- BIN_DIG, 32, data word width
- REG_NUM, 32, number of general registers (index width 5)

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset; asynchronous, active-low
- exec_valid  in  1  execute stage has an rd result this cycle
- exec_rd  in  5  execute destination register
- exec_value  in  BIN_DIG  execute result
- load_active  in  1  data-memory stage has a load result this cycle
- load_rd  in  5  load destination register
- load_value  in  BIN_DIG  load result, already sign- or zero-extended
- stall  in  1  hold the pending register; ignore new inputs
- flush  in  1  discard the pending result
- rs1_addr, rs2_addr  in  5 each  read addresses
- rs1_data, rs2_data  out  BIN_DIG each  read data
- curr_general_reg  out  REG_NUM x BIN_DIG  full register array
- instret  out  64  count of committed results
- collision_err  out  1  sticky flag: both sources were valid in the same cycle

## Operation
- **Capture stage.** Each cycle without stall or flush, the pending register (pend_valid, pend_rd, pend_data) loads the selected source:
  - load_active has priority over exec_valid.
  - If neither source is valid, pend_valid is 0.
- **Collision.** If load_active and exec_valid are both 1, the exec result is dropped and collision_err is set to 1. collision_err stays 1 until reset.
- **Commit stage.** When pend_valid=1 and stall=0 and flush=0:
  - the array entry at pend_rd takes pend_data, unless pend_rd=0;
  - instret increments, including when pend_rd=0.
- **Register 0.** x0 always reads 0, on rs1/rs2 and on curr_general_reg[0]. Writes to x0 are discarded.
- **Stall.** The pending register holds, no commit happens, and inputs are ignored. Upstream holds its outputs.
- **Flush.** pend_valid clears on the next edge, with no commit of the pending result. flush has priority over stall. Inputs presented in a flush cycle are discarded.
- **Reads.** Reads are combinational from the array. With bypass enabled, a read hits the pending result when pend_valid=1, pend_rd equals the read address, and the address is not 0.
- **Arithmetic.** instret wraps modulo 2^64.

## Timing
- **Reset values (asynchronous):**
  - all array entries 0;
  - pend_valid=0, pend_rd=0, pend_data=0;
  - instret=0, collision_err=0;
  - rs1_data and rs2_data therefore read 0.
- **Reset mid-operation.** An uncommitted pending result is lost. No partial write occurs.
- **Latency.** A result presented in cycle N is captured at the end of N and committed at the end of N+1. It is visible on the array and read ports in N+2, or in N+1 with bypass.
- **Throughput.** One result per cycle. Back-to-back writes to the same rd commit in order, and the later value wins.
- **Simultaneous commit and read of the same register** in the commit cycle:
  - without bypass, the old value is returned;
  - with bypass, the pending value is returned.

## Configuration
- **WB_BYPASS_EN defined:** the read ports forward pend_data as described under Reads.
- **WB_BYPASS_EN undefined:** the read ports return array contents only. Upstream must insert one extra cycle of hazard spacing.

## Structure
- The shared package holds:
  - BIN_DIG, REG_NUM and the register-index width;
  - a typedef wb_entry_t {valid, rd, data} used for the pending register.
- One sub-module, regfile_core: the 32-entry array with one write port, two read ports and the array output, including the x0 rule. Capture, arbitration, commit, counter and bypass live in regfile_writeback.

## Test plan
- **Load path:** load_active=1, load_rd=5, load_value=0xDEADBEEF in cycle 0 → rs1_addr=5 reads 0xDEADBEEF in cycle 2 (cycle 1 with WB_BYPASS_EN); instret=1.
- **x0 write:** exec_valid=1, exec_rd=0, exec_value=0x1234 → curr_general_reg[0] stays 0; instret increments.
- **Collision:** load (rd=3, 0x11) and exec (rd=4, 0x22) both valid in one cycle → x3=0x11, x4 unchanged, collision_err=1 and sticky.
- **Stall/flush:** capture rd=7, 0xAA; stall 3 cycles, then flush → x7 stays 0 and instret unchanged. Repeat without flush → x7=0xAA one cycle after stall drops.
- **Ordering:** back-to-back writes to rd=9 of 1, then 2 → x9=2 after the commits. With bypass, rs2 reads 1 then 2 in consecutive cycles.
- **Async reset:** assert rst_n=0 mid-stream with a pending write → all registers, instret and collision_err are 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/regfile_writeback_pkg.sv
// Shared widths and the pending-result record for the writeback stage.
package regfile_writeback_pkg;

  localparam int unsigned BIN_DIG   = 32;
  localparam int unsigned REG_NUM   = 32;
  localparam int unsigned REG_IDX_W = 5;

  typedef struct packed {
    logic                 valid;
    logic [REG_IDX_W-1:0] rd;
    logic [BIN_DIG-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_core.sv
// General register array: one write port, two combinational read ports, full array out.
// x0 is hard-wired to zero on every output and never written.
import regfile_writeback_pkg::*;

module regfile_core #(
  parameter int unsigned BIN_DIG = 32,
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned IDX_W   = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            i_we,
  input  logic [IDX_W-1:0]                i_waddr,
  input  logic [BIN_DIG-1:0]              i_wdata,
  input  logic [IDX_W-1:0]                i_raddr1,
  input  logic [IDX_W-1:0]                i_raddr2,
  output logic [BIN_DIG-1:0]              o_rdata1,
  output logic [BIN_DIG-1:0]              o_rdata2,
  output logic [REG_NUM-1:0][BIN_DIG-1:0] o_regs
);

  logic [REG_NUM-1:0][BIN_DIG-1:0] r_regs;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  always_comb begin
    o_regs    = r_regs;
    o_regs[0] = '0;
    o_rdata1  = (i_raddr1 == '0) ? '0 : r_regs[i_raddr1];
    o_rdata2  = (i_raddr2 == '0) ? '0 : r_regs[i_raddr2];
  end

endmodule

// File: rtl/regfile_writeback.sv
// Writeback stage: capture one result per cycle, commit into the register file, count commits.
// Define WB_BYPASS_EN to forward the pending result to the read ports one cycle early.
import regfile_writeback_pkg::*;

module regfile_writeback #(
  parameter int unsigned BIN_DIG = 32,
  parameter int unsigned REG_NUM = 32
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            exec_valid,
  input  logic [REG_IDX_W-1:0]            exec_rd,
  input  logic [BIN_DIG-1:0]              exec_value,
  input  logic                            load_active,
  input  logic [REG_IDX_W-1:0]            load_rd,
  input  logic [BIN_DIG-1:0]              load_value,
  input  logic                            stall,
  input  logic                            flush,
  input  logic [REG_IDX_W-1:0]            rs1_addr,
  input  logic [REG_IDX_W-1:0]            rs2_addr,
  output logic [BIN_DIG-1:0]              rs1_data,
  output logic [BIN_DIG-1:0]              rs2_data,
  output logic [REG_NUM-1:0][BIN_DIG-1:0] curr_general_reg,
  output logic [63:0]                     instret,
  output logic                            collision_err
);

  wb_entry_t          r_pend;
  wb_entry_t          w_pend_d;
  logic [63:0]        r_instret;
  logic               r_coll;
  logic               w_take;
  logic               w_commit;
  logic [BIN_DIG-1:0] w_rdata1;
  logic [BIN_DIG-1:0] w_rdata2;

  assign w_take   = !stall && !flush;
  assign w_commit = r_pend.valid && w_take;

  // Load wins over exec; flush beats stall and drops whatever is presented.
  always_comb begin
    w_pend_d = r_pend;
    if (flush) begin
      w_pend_d.valid = 1'b0;
    end else if (!stall) begin
      if (load_active) begin
        w_pend_d = '{valid: 1'b1, rd: load_rd, data: load_value};
      end else if (exec_valid) begin
        w_pend_d = '{valid: 1'b1, rd: exec_rd, data: exec_value};
      end else begin
        w_pend_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend    <= '0;
      r_instret <= '0;
      r_coll    <= 1'b0;
    end else begin
      r_pend <= w_pend_d;
      if (w_commit) begin
        r_instret <= r_instret + 64'd1;
      end
      if (w_take && load_active && exec_valid) begin
        r_coll <= 1'b1;
      end
    end
  end

  regfile_core #(
    .BIN_DIG (BIN_DIG),
    .REG_NUM (REG_NUM),
    .IDX_W   (REG_IDX_W)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_we     (w_commit),
    .i_waddr  (r_pend.rd),
    .i_wdata  (r_pend.data),
    .i_raddr1 (rs1_addr),
    .i_raddr2 (rs2_addr),
    .o_rdata1 (w_rdata1),
    .o_rdata2 (w_rdata2),
    .o_regs   (curr_general_reg)
  );

`ifdef WB_BYPASS_EN
  always_comb begin
    rs1_data = w_rdata1;
    rs2_data = w_rdata2;
    if (r_pend.valid && (r_pend.rd == rs1_addr) && (rs1_addr != '0)) rs1_data = r_pend.data;
    if (r_pend.valid && (r_pend.rd == rs2_addr) && (rs2_addr != '0)) rs2_data = r_pend.data;
  end
`else
  assign rs1_data = w_rdata1;
  assign rs2_data = w_rdata2;
`endif

  assign instret       = r_instret;
  assign collision_err = r_coll;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a cycle-level reference model of the stage rules.
module tb_regfile_writeback;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              exec_valid, load_active, stall, flush;
  logic [4:0]        exec_rd, load_rd, rs1_addr, rs2_addr;
  logic [31:0]       exec_value, load_value, rs1_data, rs2_data;
  logic [31:0][31:0] curr_general_reg;
  logic [63:0]       instret;
  logic              collision_err;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic        chk_en = 1'b0;

  // Reference state
  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_prd;
  logic [31:0] m_pdata;
  logic [63:0] m_instret;
  logic        m_coll;

  regfile_writeback dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exec_valid       (exec_valid),
    .exec_rd          (exec_rd),
    .exec_value       (exec_value),
    .load_active      (load_active),
    .load_rd          (load_rd),
    .load_value       (load_value),
    .stall            (stall),
    .flush            (flush),
    .rs1_addr         (rs1_addr),
    .rs2_addr         (rs2_addr),
    .rs1_data         (rs1_data),
    .rs2_data         (rs2_data),
    .curr_general_reg (curr_general_reg),
    .instret          (instret),
    .collision_err    (collision_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pv = 0; m_prd = '0; m_pdata = '0; m_instret = '0; m_coll = 0;
  endtask

  // One clock edge of the stage, expressed as the commit rule followed by the capture rule.
  task automatic model_step();
    if (m_pv && !stall && !flush) begin
      if (m_prd != 0) m_regs[m_prd] = m_pdata;
      m_instret = m_instret + 64'd1;
    end
    if (flush) begin
      m_pv = 0;
    end else if (!stall) begin
      if (load_active) begin
        m_pv = 1; m_prd = load_rd; m_pdata = load_value;
        if (exec_valid) m_coll = 1;
      end else if (exec_valid) begin
        m_pv = 1; m_prd = exec_rd; m_pdata = exec_value;
      end else begin
        m_pv = 0;
      end
    end
  endtask

  function automatic logic [31:0] exp_read(input logic [4:0] a);
    if (a == 5'd0) return '0;
`ifdef WB_BYPASS_EN
    if (m_pv && m_prd == a) return m_pdata;
`endif
    return m_regs[a];
  endfunction

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("rs1_data", 64'(rs1_data), 64'(exp_read(rs1_addr)));
      chk("rs2_data", 64'(rs2_data), 64'(exp_read(rs2_addr)));
      chk("instret", instret, m_instret);
      chk("collision_err", 64'(collision_err), 64'(m_coll));
      for (int i = 0; i < 32; i++)
        chk($sformatf("reg[%0d]", i), 64'(curr_general_reg[i]), 64'(m_regs[i]));
    end
  end

  task automatic idle();
    exec_valid = 0; exec_rd = '0; exec_value = '0;
    load_active = 0; load_rd = '0; load_value = '0;
    stall = 0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    rst_n = 0; idle(); rs1_addr = 5'd3; rs2_addr = 5'd7;
    model_reset();
    #2;
    chk("reset rs1", 64'(rs1_data), 64'd0);
    chk("reset instret", instret, 64'd0);
    chk("reset coll", 64'(collision_err), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1; chk_en = 1;

    // Load path
    load_active = 1; load_rd = 5'd5; load_value = 32'hDEADBEEF; rs1_addr = 5'd5;
    tick(); idle();
`ifdef WB_BYPASS_EN
    chk("load early rs1", 64'(rs1_data), 64'hDEADBEEF);
`else
    chk("load early rs1", 64'(rs1_data), 64'h0);
`endif
    tick();
    chk("load rs1", 64'(rs1_data), 64'hDEADBEEF);
    chk("load instret", instret, 64'd1);

    // x0 write
    exec_valid = 1; exec_rd = 5'd0; exec_value = 32'h1234; rs1_addr = 5'd0;
    tick(); idle(); tick(); tick();
    chk("x0 reg", 64'(curr_general_reg[0]), 64'd0);
    chk("x0 rs1", 64'(rs1_data), 64'd0);
    chk("x0 instret", instret, 64'd2);

    // Collision
    load_active = 1; load_rd = 5'd3; load_value = 32'h11;
    exec_valid = 1; exec_rd = 5'd4; exec_value = 32'h22;
    tick(); idle(); tick(); tick();
    chk("coll x3", 64'(curr_general_reg[3]), 64'h11);
    chk("coll x4", 64'(curr_general_reg[4]), 64'h0);
    chk("coll flag", 64'(collision_err), 64'd1);
    tick(); tick();
    chk("coll sticky", 64'(collision_err), 64'd1);

    // Stall then flush; input in the flush cycle is dropped
    load_active = 1; load_rd = 5'd7; load_value = 32'hAA;
    tick(); idle(); stall = 1;
    repeat (3) tick();
    stall = 0; flush = 1; exec_valid = 1; exec_rd = 5'd10; exec_value = 32'h77;
    tick(); idle(); tick(); tick();
    chk("flush x7", 64'(curr_general_reg[7]), 64'h0);
    chk("flush x10", 64'(curr_general_reg[10]), 64'h0);
    chk("flush instret", instret, 64'd3);

    // Stall then release; input presented during stall is ignored
    load_active = 1; load_rd = 5'd7; load_value = 32'hAA;
    tick(); idle(); stall = 1; load_active = 1; load_rd = 5'd8; load_value = 32'h55;
    tick(); idle(); stall = 1;
    tick(); tick();
    stall = 0;
    tick();
    chk("stall x7", 64'(curr_general_reg[7]), 64'hAA);
    chk("stall x8", 64'(curr_general_reg[8]), 64'h0);
    chk("stall instret", instret, 64'd4);

    // Back-to-back writes to x9
    exec_valid = 1; exec_rd = 5'd9; exec_value = 32'd1; rs2_addr = 5'd9;
    tick(); exec_value = 32'd2;
`ifdef WB_BYPASS_EN
    chk("order rs2 a", 64'(rs2_data), 64'd1);
`else
    chk("order rs2 a", 64'(rs2_data), 64'd0);
`endif
    tick(); idle();
`ifdef WB_BYPASS_EN
    chk("order rs2 b", 64'(rs2_data), 64'd2);
`else
    chk("order rs2 b", 64'(rs2_data), 64'd1);
`endif
    tick();
    chk("order x9", 64'(curr_general_reg[9]), 64'd2);
    chk("order instret", instret, 64'd6);

    // Asynchronous reset with a pending write
    exec_valid = 1; exec_rd = 5'd11; exec_value = 32'h99; rs1_addr = 5'd3;
    tick(); idle();
    #2 rst_n = 0; model_reset();
    #1;
    chk("arst instret", instret, 64'd0);
    chk("arst coll", 64'(collision_err), 64'd0);
    chk("arst x3", 64'(curr_general_reg[3]), 64'd0);
    chk("arst x7", 64'(curr_general_reg[7]), 64'd0);
    chk("arst rs1", 64'(rs1_data), 64'd0);
    #3 rst_n = 1;
    repeat (3) tick();
    chk("post x11", 64'(curr_general_reg[11]), 64'd0);
    chk("post instret", instret, 64'd0);

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
